// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and sequencer in front of sram_controller.
//
// Collects single-byte read/write requests from two requesters and serialises
// them onto the controller's address/data_in/read_en/write_en interface. The
// selected enable is held for READ_CYCLES or WRITE_CYCLES clocks, then a DONE
// cycle idles the controller and a one-cycle ack is issued to the granted port.
//
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_req0/1, i_we0/1              request and op (1 = write, 0 = read), held until ack
//   i_addr0/1, i_wdata0/1          request address and write data
//   o_ack0/1                       one-cycle completion pulse
//   o_rdata0/1                     read data, held until that port's next read completes
//   o_ctrl_address, o_ctrl_data_in to sram_controller address / data_in
//   o_ctrl_read_en, o_ctrl_write_en to sram_controller read_en / write_en
//   i_ctrl_data_out                from sram_controller data_out
//   o_busy                         high whenever the sequencer is not idle
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an eligible request; grants on the closing edge
// READ  | read_en asserted for READ_CYCLES cycles
// WRITE | write_en asserted for WRITE_CYCLES cycles
// DONE  | enables low; ack and read data registered on the closing edge
module sram_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_wdata0,
    output logic              o_ack0,
    output logic [DATA_W-1:0] o_rdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [ADDR_W-1:0] o_ctrl_address,
    output logic [DATA_W-1:0] o_ctrl_data_in,
    output logic              o_ctrl_read_en,
    output logic              o_ctrl_write_en,
    input  logic [DATA_W-1:0] i_ctrl_data_out,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Terminal counts: the counter starts at 0 on the first enabled cycle.
    localparam logic [3:0] RD_LAST = 4'(READ_CYCLES - 1);
    localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_counter;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant_valid;
    logic              w_grant_port;
    logic              w_sel_we;
    logic              w_term;

    // A port whose ack is showing this cycle sits out one arbitration round,
    // so a requester that has not yet dropped req is not granted twice.
    assign w_elig0       = i_req0 & ~r_ack0;
    assign w_elig1       = i_req1 & ~r_ack1;
    assign w_grant_valid = w_elig0 | w_elig1;

    always_comb begin
        w_grant_port = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_grant_port = ~r_last_grant;
        end else if (w_elig1) begin
            w_grant_port = 1'b1;
        end
    end

    assign w_sel_we = w_grant_port ? i_we1 : i_we0;

    always_comb begin
        w_next_state = r_state;
        w_term       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_next_state = w_sel_we ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                w_term = (r_counter == RD_LAST);
                if (w_term) begin
                    w_next_state = S_DONE;
                end
            end
            S_WRITE: begin
                w_term = (r_counter == WR_LAST);
                if (w_term) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_counter    <= 4'd0;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_grant      <= w_grant_port;
                        r_last_grant <= w_grant_port;
                        r_we         <= w_sel_we;
                        r_addr       <= w_grant_port ? i_addr1 : i_addr0;
                        r_wdata      <= w_grant_port ? i_wdata1 : i_wdata0;
                        r_counter    <= 4'd0;
                    end
                end
                S_READ, S_WRITE: begin
                    // Hold at the terminal count rather than wrapping.
                    if (!w_term) begin
                        r_counter <= r_counter + 4'd1;
                    end
                end
                S_DONE: begin
                    if (r_grant) begin
                        r_ack1 <= 1'b1;
                        if (!r_we) begin
                            r_rdata1 <= i_ctrl_data_out;
                        end
                    end else begin
                        r_ack0 <= 1'b1;
                        if (!r_we) begin
                            r_rdata0 <= i_ctrl_data_out;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ack0          = r_ack0;
    assign o_ack1          = r_ack1;
    assign o_rdata0        = r_rdata0;
    assign o_rdata1        = r_rdata1;
    assign o_ctrl_address  = r_addr;
    assign o_ctrl_data_in  = r_wdata;
    assign o_ctrl_read_en  = (r_state == S_READ);
    assign o_ctrl_write_en = (r_state == S_WRITE);
    assign o_busy          = (r_state != S_IDLE);

endmodule
